// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter with an IDLE/ISSUE/RESP FSM and one outstanding access.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority to m0.
module mem_arbiter (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_m0_req,
    input  logic        i_m0_wren,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wdata,
    input  logic [3:0]  i_m0_bmask,
    output logic        o_m0_gnt,
    output logic        o_m0_rvalid,
    output logic [31:0] o_m0_rdata,
    input  logic        i_m1_req,
    input  logic        i_m1_wren,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    input  logic [3:0]  i_m1_bmask,
    output logic        o_m1_gnt,
    output logic        o_m1_rvalid,
    output logic [31:0] o_m1_rdata,
    output logic        o_mem_en,
    output logic        o_mem_wren,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    input  logic [31:0] i_mem_rdata,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        wren_q, wren_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  bmask_q, bmask_d;
    logic        id_q, id_d;
    logic        win_s;
`ifdef ARB_ROUND_ROBIN_EN
    logic        last_q, last_d;
`endif

    // Winner select: 1 means m1 wins.
    always_comb begin
        win_s = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        if (i_m0_req && i_m1_req) begin
            win_s = ~last_q;
        end else begin
            win_s = i_m1_req;
        end
`else
        if (i_m0_req) begin
            win_s = 1'b0;
        end else begin
            win_s = i_m1_req;
        end
`endif
    end

    // Next-state and transaction latch logic.
    always_comb begin
        state_d = state_q;
        wren_d  = wren_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        bmask_d = bmask_q;
        id_d    = id_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_m0_req || i_m1_req) begin
                    state_d = ST_ISSUE;
                    id_d    = win_s;
                    if (win_s) begin
                        wren_d  = i_m1_wren;
                        addr_d  = i_m1_addr;
                        wdata_d = i_m1_wdata;
                        bmask_d = i_m1_bmask;
                    end else begin
                        wren_d  = i_m0_wren;
                        addr_d  = i_m0_addr;
                        wdata_d = i_m0_wdata;
                        bmask_d = i_m0_bmask;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
`ifdef ARB_ROUND_ROBIN_EN
                last_d = id_q;
`endif
                if (wren_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latched-field registers; pointer resets so that m0 wins first.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            wren_q  <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            bmask_q <= 4'd0;
            id_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            bmask_q <= bmask_d;
            id_q    <= id_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    // Output decode from registered state; the memory bus is zero when not issuing.
    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_wren  = 1'b0;
        o_mem_addr  = 32'd0;
        o_mem_wdata = 32'd0;
        o_mem_bmask = 4'd0;
        o_m0_gnt    = 1'b0;
        o_m1_gnt    = 1'b0;
        o_m0_rvalid = 1'b0;
        o_m1_rvalid = 1'b0;
        o_m0_rdata  = 32'd0;
        o_m1_rdata  = 32'd0;
        o_busy      = (state_q != ST_IDLE);
        case (state_q)
            ST_ISSUE: begin
                o_mem_en    = 1'b1;
                o_mem_wren  = wren_q;
                o_mem_addr  = {addr_q[31:2], 2'b00};
                o_mem_wdata = wdata_q;
                o_mem_bmask = bmask_q;
                if (id_q) begin
                    o_m1_gnt = 1'b1;
                end else begin
                    o_m0_gnt = 1'b1;
                end
            end
            ST_RESP: begin
                if (id_q) begin
                    o_m1_rvalid = 1'b1;
                    o_m1_rdata  = i_mem_rdata;
                end else begin
                    o_m0_rvalid = 1'b1;
                    o_m0_rdata  = i_mem_rdata;
                end
            end
            default: o_busy = (state_q != ST_IDLE);
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expectations follow the
// arbitration mode selected by ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_m0_req, i_m0_wren, i_m1_req, i_m1_wren;
    logic [31:0] i_m0_addr, i_m0_wdata, i_m1_addr, i_m1_wdata, i_mem_rdata;
    logic [3:0]  i_m0_bmask, i_m1_bmask;
    logic        o_m0_gnt, o_m0_rvalid, o_m1_gnt, o_m1_rvalid;
    logic [31:0] o_m0_rdata, o_m1_rdata;
    logic        o_mem_en, o_mem_wren, o_busy;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_bmask;

    int total = 0;
    int bad   = 0;

    mem_arbiter dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_m0_req(i_m0_req), .i_m0_wren(i_m0_wren), .i_m0_addr(i_m0_addr),
        .i_m0_wdata(i_m0_wdata), .i_m0_bmask(i_m0_bmask),
        .o_m0_gnt(o_m0_gnt), .o_m0_rvalid(o_m0_rvalid), .o_m0_rdata(o_m0_rdata),
        .i_m1_req(i_m1_req), .i_m1_wren(i_m1_wren), .i_m1_addr(i_m1_addr),
        .i_m1_wdata(i_m1_wdata), .i_m1_bmask(i_m1_bmask),
        .o_m1_gnt(o_m1_gnt), .o_m1_rvalid(o_m1_rvalid), .o_m1_rdata(o_m1_rdata),
        .o_mem_en(o_mem_en), .o_mem_wren(o_mem_wren), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask),
        .i_mem_rdata(i_mem_rdata), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
        chk({tag, "_en"}, {31'd0, o_mem_en}, 32'd0);
        chk({tag, "_gnt"}, {30'd0, o_m1_gnt, o_m0_gnt}, 32'd0);
        chk({tag, "_rv"}, {30'd0, o_m1_rvalid, o_m0_rvalid}, 32'd0);
        chk({tag, "_addr"}, o_mem_addr, 32'd0);
        chk({tag, "_wd"}, o_mem_wdata, 32'd0);
        chk({tag, "_bm"}, {28'd0, o_mem_bmask}, 32'd0);
        chk({tag, "_rd"}, o_m0_rdata | o_m1_rdata, 32'd0);
    endtask

    logic exp_m1;

    initial begin
        i_reset = 1'b0;
        i_m0_req = 1'b0; i_m0_wren = 1'b0; i_m0_addr = 32'd0; i_m0_wdata = 32'd0; i_m0_bmask = 4'd0;
        i_m1_req = 1'b0; i_m1_wren = 1'b0; i_m1_addr = 32'd0; i_m1_wdata = 32'd0; i_m1_bmask = 4'd0;
        i_mem_rdata = 32'hCAFE_F00D;
        tick();
        tick();
        chk_idle("reset");
        i_reset = 1'b1;

        // Single write from m0 with misaligned address.
        i_m0_req = 1'b1; i_m0_wren = 1'b1; i_m0_addr = 32'h0000_1006;
        i_m0_wdata = 32'hDEAD_BEEF; i_m0_bmask = 4'b1100;
        tick();
        chk("wr_en", {31'd0, o_mem_en}, 32'd1);
        chk("wr_wren", {31'd0, o_mem_wren}, 32'd1);
        chk("wr_addr", o_mem_addr, 32'h0000_1004);
        chk("wr_wdata", o_mem_wdata, 32'hDEAD_BEEF);
        chk("wr_bmask", {28'd0, o_mem_bmask}, 32'h0000_000C);
        chk("wr_gnt", {30'd0, o_m1_gnt, o_m0_gnt}, 32'd1);
        chk("wr_busy", {31'd0, o_busy}, 32'd1);
        i_m0_req = 1'b0;
        tick();
        chk_idle("wr_done");

        // Single read from m1.
        i_m1_req = 1'b1; i_m1_wren = 1'b0; i_m1_addr = 32'h0000_0020; i_m1_bmask = 4'hF;
        i_mem_rdata = 32'h1234_5678;
        tick();
        chk("rd_gnt", {30'd0, o_m1_gnt, o_m0_gnt}, 32'd2);
        chk("rd_addr", o_mem_addr, 32'h0000_0020);
        chk("rd_wren", {31'd0, o_mem_wren}, 32'd0);
        i_m1_req = 1'b0;
        tick();
        chk("rd_rvalid", {30'd0, o_m1_rvalid, o_m0_rvalid}, 32'd2);
        chk("rd_rdata1", o_m1_rdata, 32'h1234_5678);
        chk("rd_rdata0", o_m0_rdata, 32'd0);
        chk("rd_en_resp", {31'd0, o_mem_en}, 32'd0);
        chk("rd_busy_resp", {31'd0, o_busy}, 32'd1);
        tick();
        chk_idle("rd_done");

        // m1 requests during an m0 read response.
        i_m0_req = 1'b1; i_m0_wren = 1'b0; i_m0_addr = 32'h0000_0040;
        i_mem_rdata = 32'h0BAD_0040;
        tick();
        chk("bz_gnt0", {30'd0, o_m1_gnt, o_m0_gnt}, 32'd1);
        i_m0_req = 1'b0;
        tick();
        chk("bz_rv0", {30'd0, o_m1_rvalid, o_m0_rvalid}, 32'd1);
        chk("bz_rd0", o_m0_rdata, 32'h0BAD_0040);
        i_m1_req = 1'b1; i_m1_wren = 1'b0; i_m1_addr = 32'h0000_0080;
        tick();
        chk("bz_idle_gnt", {30'd0, o_m1_gnt, o_m0_gnt}, 32'd0);
        chk("bz_idle_busy", {31'd0, o_busy}, 32'd0);
        tick();
        chk("bz_gnt1", {30'd0, o_m1_gnt, o_m0_gnt}, 32'd2);
        chk("bz_addr1", o_mem_addr, 32'h0000_0080);
        i_m1_req = 1'b0;
        i_mem_rdata = 32'h0BAD_0080;
        tick();
        chk("bz_rv1", {30'd0, o_m1_rvalid, o_m0_rvalid}, 32'd2);
        chk("bz_rd1", o_m1_rdata, 32'h0BAD_0080);
        tick();
        chk_idle("bz_done");
        tick();
        chk("bz_nodup", {30'd0, o_m1_gnt, o_m0_gnt}, 32'd0);

        // Early drop: fields change after latch, issue keeps latched values.
        i_m0_req = 1'b1; i_m0_wren = 1'b1; i_m0_addr = 32'h0000_0100;
        i_m0_wdata = 32'hA5A5_A5A5; i_m0_bmask = 4'b0011;
        tick();
        i_m0_req = 1'b0; i_m0_addr = 32'h0000_FFFF; i_m0_wdata = 32'h0; i_m0_bmask = 4'hF;
        #1;
        chk("ed_gnt", {30'd0, o_m1_gnt, o_m0_gnt}, 32'd1);
        chk("ed_addr", o_mem_addr, 32'h0000_0100);
        chk("ed_wdata", o_mem_wdata, 32'hA5A5_A5A5);
        chk("ed_bmask", {28'd0, o_mem_bmask}, 32'h0000_0003);
        tick();
        chk_idle("ed_after");
        tick();
        chk("ed_once", {30'd0, o_m1_gnt, o_m0_gnt}, 32'd0);

        // Contention from reset: both read continuously.
        i_reset = 1'b0;
        tick();
        i_reset = 1'b1;
        i_m0_req = 1'b1; i_m0_wren = 1'b0; i_m0_addr = 32'h0000_0200;
        i_m1_req = 1'b1; i_m1_wren = 1'b0; i_m1_addr = 32'h0000_0300;
        for (int k = 0; k < 4; k++) begin
            tick();
`ifdef ARB_ROUND_ROBIN_EN
            exp_m1 = k[0];
`else
            exp_m1 = 1'b0;
`endif
            chk($sformatf("ct_gnt%0d", k), {30'd0, o_m1_gnt, o_m0_gnt},
                exp_m1 ? 32'd2 : 32'd1);
            chk($sformatf("ct_addr%0d", k), o_mem_addr,
                exp_m1 ? 32'h0000_0300 : 32'h0000_0200);
            tick();
            tick();
        end

        // Reset during ISSUE of an m0 read.
        i_m1_req = 1'b0;
        tick();
        chk("rs_gnt", {30'd0, o_m1_gnt, o_m0_gnt}, 32'd1);
        i_reset = 1'b0;
        tick();
        chk_idle("rs_now");
        tick();
        chk("rs_norv", {30'd0, o_m1_rvalid, o_m0_rvalid}, 32'd0);
        i_reset = 1'b1;
        i_m1_req = 1'b1;
        tick();
        chk("rs_first", {30'd0, o_m1_gnt, o_m0_gnt}, 32'd1);
        chk("rs_addr", o_mem_addr, 32'h0000_0200);
        i_m0_req = 1'b0; i_m1_req = 1'b0;
        tick();
        tick();
        chk_idle("rs_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
